// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit retired per clock.
// Optional two's-complement mode enabled by defining SEQ_MUL_SIGNED_EN.
module seq_shift_add_multiplier #(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 4
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic                       sgn_in,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a_in,
    input  logic [WIDTH_B-1:0]         b_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] product,
    output logic                       busy
);

    localparam int WIDTH_P = WIDTH_A + WIDTH_B;
    localparam int CW      = $clog2(WIDTH_B + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH_P-1:0] a_sh;
    logic [WIDTH_P-1:0] acc;
    logic [WIDTH_P-1:0] pp;
    logic [WIDTH_P-1:0] nxt;
    logic [WIDTH_P-1:0] a_ext;
    logic [WIDTH_B-1:0] b_sh;
    logic [CW-1:0]      cnt;
    logic               last;

`ifdef SEQ_MUL_SIGNED_EN
    logic sgn_q;

    assign a_ext = sgn_in ? {{WIDTH_B{a_in[WIDTH_A-1]}}, a_in}
                          : {{WIDTH_B{1'b0}}, a_in};
`else
    assign a_ext = {{WIDTH_B{1'b0}}, a_in};
`endif

    always_comb begin
        last = (cnt == CW'(WIDTH_B - 1));
        pp   = b_sh[0] ? a_sh : '0;
        nxt  = acc + pp;
`ifdef SEQ_MUL_SIGNED_EN
        // In signed mode the MSB of b carries negative weight.
        if (sgn_q && last)
            nxt = acc - pp;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            cnt       <= '0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sgn_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a_ext;
                        b_sh     <= b_in;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
                        sgn_q    <= sgn_in;
`endif
                    end
                end
                BUSY: begin
                    acc  <= nxt;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        product   <= nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier, 4x4 and 8x8 instances.
// Signed vectors run only when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        sgn_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  a_in;
    logic [3:0]  b_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  product;
    logic        busy;

    logic        sgn_in8;
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a_in8;
    logic [7:0]  b_in8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] product8;
    logic        busy8;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_shift_add_multiplier #(.WIDTH_A(4), .WIDTH_B(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
`ifdef SEQ_MUL_SIGNED_EN
        .sgn_in    (sgn_in),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    seq_shift_add_multiplier #(.WIDTH_A(8), .WIDTH_B(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
`ifdef SEQ_MUL_SIGNED_EN
        .sgn_in    (sgn_in8),
`endif
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a_in      (a_in8),
        .b_in      (b_in8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8),
        .busy      (busy8)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        input logic s, input logic [7:0] exp,
                        input string tag);
        int  n;
        logic ir_hi;
        a_in      = a;
        b_in      = b;
        sgn_in    = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        n         = 1;
        ir_hi     = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready) ir_hi = 1'b1;
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 5);
        check({tag, "_rdy"}, ir_hi | in_ready, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_prod"}, product, exp);
        tick();
        check({tag, "_ret"}, out_valid, 0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string tag);
        int n;
        a_in8      = a;
        b_in8      = b;
        in_valid8  = 1'b1;
        out_ready8 = 1'b1;
        tick();
        in_valid8  = 1'b0;
        n          = 1;
        while (!out_valid8 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 9);
        check({tag, "_prod"}, product8, exp);
        tick();
        check({tag, "_ret"}, out_valid8, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int g;
        int prev;
        int acc_c;
        rst        = 1'b1;
        sgn_in     = 1'b0;
        in_valid   = 1'b0;
        a_in       = '0;
        b_in       = '0;
        out_ready  = 1'b0;
        sgn_in8    = 1'b0;
        in_valid8  = 1'b0;
        a_in8      = '0;
        b_in8      = '0;
        out_ready8 = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);
        check("rst_product8", product8, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        run4(4'd15, 4'd15, 1'b0, 8'd225, "t1");

        in_valid  = 1'b1;
        out_ready = 1'b1;
        prev      = -1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                g = 0;
                while (!in_ready && g < 20) begin
                    tick();
                    g++;
                end
                a_in = a[3:0];
                b_in = b[3:0];
                tick();
                acc_c = cyc;
                if (prev >= 0) check("t2_period", acc_c - prev, 6);
                prev = acc_c;
                g = 0;
                while (!out_valid && g < 20) begin
                    tick();
                    g++;
                end
                check("t2_prod", product, a * b);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();

        a_in      = 4'd9;
        b_in      = 4'd7;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        a_in = 4'd1;
        b_in = 4'd1;
        g    = 0;
        while (!out_valid && g < 20) begin
            tick();
            g++;
        end
        for (int i = 0; i < 20; i++) begin
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_prod", product, 63);
            check("t3_hold_rdy", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t3_ret_valid", out_valid, 0);
        check("t3_ret_rdy", in_ready, 1);
        check("t3_keep_prod", product, 63);

        a_in     = 4'd15;
        b_in     = 4'd15;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t4_valid", out_valid, 0);
        check("t4_prod", product, 0);
        check("t4_rdy", in_ready, 1);
        check("t4_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        run4(4'd3, 4'd5, 1'b0, 8'd15, "t4");

        run8(8'd255, 8'd0, 16'd0, "t5a");
        run8(8'd200, 8'd201, 16'd40200, "t5b");

`ifdef SEQ_MUL_SIGNED_EN
        run4(4'h8, 4'h8, 1'b1, 8'h40, "t6a");
        run4(4'hD, 4'h5, 1'b1, 8'hF1, "t6b");
        run4(4'hD, 4'h5, 1'b0, 8'd65, "t6c");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
